// File: rtl/z3_dma_burst_master.sv
// Zorro III DMA master cycle sequencer: buffer enables, FCS, DOE and DS strobes.
// Optional multi-beat (MTCR) bursts are built when Z3_DMA_BURST_EN is defined.
module z3_dma_burst_master #(
    parameter int BURST_MAX      = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int DS_SETUP       = 1
) (
    input  logic                           bclk,
    input  logic                           IORST,
    input  logic                           mybus,
    input  logic                           req,
    input  logic                           read,
    input  logic [1:0]                     addrl,
    input  logic [1:0]                     siz,
    input  logic [$clog2(BURST_MAX+1)-1:0] beats,
    input  logic                           fcs_in_n,
    input  logic                           dtack_n,
    input  logic                           slave_n,
    output logic                           aboel,
    output logic                           aboeh,
    output logic                           efcs,
    output logic                           doe,
    output logic [3:0]                     ds_n,
    output logic                           mtcr,
    output logic                           beat_ack,
    output logic                           done,
    output logic                           err
);

    localparam int BW      = $clog2(BURST_MAX + 1);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > DS_SETUP) ? TIMEOUT_CYCLES : DS_SETUP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] S_LAST = CW'(DS_SETUP - 1);

    typedef enum logic [2:0] {
        IDLE, ARB, ADDR, FCS, DOE, DATA, BEAT, TERM
    } state_t;

    state_t      state, state_nx;
    logic [CW-1:0] cnt;
    logic        keep;
    logic        busfree, busfree_q;
    logic        more;
    logic        ok_go, to_go;
    logic        ok_pend, err_pend;
    logic        rd_q;
    logic [1:0]  addrl_q, siz_q;
    logic [3:0]  lane_n;
    logic [2:0]  sz_bytes, last;

    assign aboel   = mybus & ~IORST;
    assign keep    = mybus & req;
    assign busfree = fcs_in_n & dtack_n & slave_n & (ds_n == 4'b1111);

`ifdef Z3_DMA_BURST_EN
    localparam logic [BW-1:0] BMAX = BW'(BURST_MAX);
    logic [BW-1:0] left;
    logic          mtcr_q;

    // Beats remaining in this tenure and the MTCR toggle per extra beat
    always_ff @(posedge bclk) begin
        if (IORST) begin
            left   <= '0;
            mtcr_q <= 1'b0;
        end else if (state == IDLE && keep) begin
            if (beats == '0)
                left <= BW'(1);
            else if (beats > BMAX)
                left <= BMAX;
            else
                left <= beats;
        end else if (state == BEAT && state_nx == DOE) begin
            left   <= left - BW'(1);
            mtcr_q <= ~mtcr_q;
        end
    end

    assign more = (left > BW'(1));
    assign mtcr = mtcr_q;
`else
    logic unused_beats;
    assign unused_beats = ^beats;
    assign more = 1'b0;
    assign mtcr = 1'b0;
`endif

    // State register
    always_ff @(posedge bclk) begin
        if (IORST)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state and strobe decode; ARB needs the bus free on two
    // consecutive samples so a one-cycle gap between cycles is not taken
    always_comb begin
        state_nx = state;
        ok_go    = 1'b0;
        to_go    = 1'b0;
        unique case (state)
            IDLE: if (keep) state_nx = ARB;
            ARB: begin
                if (!keep)
                    state_nx = IDLE;
                else if (busfree && busfree_q)
                    state_nx = ADDR;
            end
            ADDR: state_nx = keep ? FCS : TERM;
            FCS:  state_nx = keep ? DOE : TERM;
            DOE: begin
                if (!keep)
                    state_nx = TERM;
                else if (cnt == S_LAST)
                    state_nx = DATA;
            end
            DATA: begin
                if (!keep) begin
                    state_nx = TERM;
                end else if (!dtack_n) begin
                    state_nx = BEAT;
                end else if (cnt == T_LAST) begin
                    state_nx = TERM;
                    to_go    = 1'b1;
                end
            end
            BEAT: begin
                if (!keep) begin
                    state_nx = TERM;
                end else if (more) begin
                    state_nx = DOE;
                end else begin
                    state_nx = TERM;
                    ok_go    = 1'b1;
                end
            end
            TERM:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        aboeh    = state inside {ADDR, FCS, DOE, DATA, BEAT};
        efcs     = state inside {FCS, DOE, DATA, BEAT};
        doe      = state inside {DOE, DATA, BEAT};
        ds_n     = (state == DATA) ? lane_n : 4'b1111;
        beat_ack = (state == BEAT);
        done     = (state == TERM) && ok_pend;
        err      = (state == TERM) && err_pend;
    end

    // Byte-lane mask; lane for byte address a sits on ds_n[3-a]
    always_comb begin
        unique case (siz_q)
            2'b00:   sz_bytes = 3'd4;
            2'b01:   sz_bytes = 3'd1;
            2'b10:   sz_bytes = 3'd2;
            default: sz_bytes = 3'd3;
        endcase
        last   = {1'b0, addrl_q} + sz_bytes - 3'd1;
        lane_n = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) >= {1'b0, addrl_q} && 3'(i) <= last)
                lane_n[3-i] = 1'b0;
        end
        if (rd_q)
            lane_n = 4'b0000;
    end

    // Phase counter, bus-free history, beat attributes and end cause
    always_ff @(posedge bclk) begin
        if (IORST) begin
            cnt       <= '0;
            busfree_q <= 1'b0;
            rd_q      <= 1'b0;
            addrl_q   <= 2'b00;
            siz_q     <= 2'b00;
            ok_pend   <= 1'b0;
            err_pend  <= 1'b0;
        end else begin
            busfree_q <= busfree;
            if (state_nx != state)
                cnt <= '0;
            else if (state == DOE || state == DATA)
                cnt <= cnt + CW'(1);
            if (state_nx == DOE && state != DOE) begin
                rd_q    <= read;
                addrl_q <= addrl;
                siz_q   <= siz;
            end
            if (state_nx == TERM && state != TERM) begin
                ok_pend  <= ok_go;
                err_pend <= to_go;
            end
        end
    end

endmodule

// File: tb/tb_z3_dma_burst_master.sv
// Directed bench for z3_dma_burst_master: lane masks, latency, timeout,
// abort, reset and burst behaviour (burst checks follow Z3_DMA_BURST_EN).
module tb_z3_dma_burst_master;

    localparam int BM = 4;
    localparam int TO = 8;
    localparam int SU = 2;
`ifdef Z3_DMA_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif
    localparam logic [9:0] IDLE_V = 10'b000_1111_000;

    logic       bclk;
    logic       IORST, mybus, req, read;
    logic [1:0] addrl, siz;
    logic [2:0] beats;
    logic       fcs_in_n, dtack_n, slave_n;
    logic       aboel, aboeh, efcs, doe;
    logic [3:0] ds_n;
    logic       mtcr, beat_ack, done, err;
    logic [9:0] st;

    int nvec = 0;
    int nerr = 0;

    assign st = {aboeh, efcs, doe, ds_n, beat_ack, done, err};

    z3_dma_burst_master #(
        .BURST_MAX(BM), .TIMEOUT_CYCLES(TO), .DS_SETUP(SU)
    ) dut (
        .bclk(bclk), .IORST(IORST), .mybus(mybus), .req(req),
        .read(read), .addrl(addrl), .siz(siz), .beats(beats),
        .fcs_in_n(fcs_in_n), .dtack_n(dtack_n), .slave_n(slave_n),
        .aboel(aboel), .aboeh(aboeh), .efcs(efcs), .doe(doe),
        .ds_n(ds_n), .mtcr(mtcr), .beat_ack(beat_ack),
        .done(done), .err(err)
    );

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    task automatic tick();
        @(posedge bclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Checks from the ADDR cycle to IDLE; DS held 'hold' cycles before DTACK
    task automatic body(input string tag, input logic [3:0] exp_ds,
                        input int hold);
        check({tag, ".addr"}, {aboeh, efcs}, 2'b10);
        tick();
        check({tag, ".fcs"}, {aboeh, efcs, doe}, 3'b110);
        for (int i = 0; i < SU; i++) begin
            tick();
            check({tag, ".doe"}, {doe, ds_n}, 5'b1_1111);
            if (i == 0) begin
                addrl = ~addrl;
                read  = ~read;
            end
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, ".ds"}, ds_n, exp_ds);
        end
        dtack_n = 1'b0;
        tick();
        check({tag, ".beat"}, {ds_n, beat_ack, doe, efcs}, 7'b1111_111);
        dtack_n = 1'b1;
        tick();
        check({tag, ".term"}, {done, err, aboeh, efcs, doe}, 5'b10000);
        req = 1'b0;
        tick();
        check({tag, ".idle"}, st, IDLE_V);
    endtask

    task automatic tenure(input string tag, input logic rd,
                          input logic [1:0] a, input logic [1:0] sz,
                          input logic [3:0] exp_ds, input int hold);
        read  = rd;
        addrl = a;
        siz   = sz;
        beats = 3'd1;
        req   = 1'b1;
        tick();
        tick();
        body(tag, exp_ds, hold);
    endtask

    task automatic to_data();
        read  = 1'b0;
        addrl = 2'd0;
        siz   = 2'd0;
        beats = 3'd1;
        req   = 1'b1;
        repeat (4 + SU) tick();
    endtask

    // Bus held busy by one input for 5 cycles of ARB, then released
    task automatic blocked(input string tag, input int sel);
        read  = 1'b0;
        addrl = 2'd0;
        siz   = 2'd0;
        beats = 3'd1;
        if (sel == 0) fcs_in_n = 1'b0;
        if (sel == 1) dtack_n  = 1'b0;
        if (sel == 2) slave_n  = 1'b0;
        req = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check({tag, ".hold"}, aboeh, 1'b0);
        end
        fcs_in_n = 1'b1;
        dtack_n  = 1'b1;
        slave_n  = 1'b1;
        tick();
        check({tag, ".rel1"}, aboeh, 1'b0);
        tick();
        body(tag, 4'b0000, 1);
    endtask

    // DTACK never (dt_at<0) or on the last timeout cycle
    task automatic slow(input string tag, input int dt_at);
        int low;
        low = 0;
        to_data();
        for (int i = 0; i < TO; i++) begin
            if (i > 0) tick();
            if (ds_n != 4'hF) low++;
            if (i == dt_at) dtack_n = 1'b0;
        end
        tick();
        dtack_n = 1'b1;
        if (dt_at < 0) begin
            check({tag, ".low"}, low, TO);
            check({tag, ".err"}, {err, done, beat_ack, ds_n}, 7'b100_1111);
        end else begin
            check({tag, ".beat"}, {beat_ack, err, ds_n}, 6'b10_1111);
            tick();
            check({tag, ".done"}, {done, err}, 2'b10);
        end
        req = 1'b0;
        tick();
        check({tag, ".idle"}, st, IDLE_V);
    endtask

    // Responsive slave: DTACK whenever strobes are out
    task automatic burst(input string tag, input logic [2:0] nb,
                         input int exp_acks);
        int   acks, tog, dn, er, gap;
        logic last_m;
        bit   seen, fin;
        acks = 0; tog = 0; dn = 0; er = 0; gap = 0;
        seen = 1'b0; fin = 1'b0;
        last_m = mtcr;
        read  = 1'b0;
        addrl = 2'd0;
        siz   = 2'd0;
        beats = nb;
        req   = 1'b1;
        for (int c = 0; c < 80 && !fin; c++) begin
            tick();
            if (beat_ack) acks++;
            if (mtcr !== last_m) tog++;
            last_m = mtcr;
            if (done) dn++;
            if (err) er++;
            if (efcs) seen = 1'b1;
            else if (seen && !done && !err) gap++;
            dtack_n = (ds_n != 4'hF) ? 1'b0 : 1'b1;
            if (done || err) begin
                fin     = 1'b1;
                req     = 1'b0;
                dtack_n = 1'b1;
            end
        end
        check({tag, ".acks"}, acks, exp_acks);
        check({tag, ".mtcr"}, tog, exp_acks - 1);
        check({tag, ".done"}, dn, 1);
        check({tag, ".err"}, er, 0);
        check({tag, ".efcs"}, gap, 0);
        tick();
        check({tag, ".idle"}, st, IDLE_V);
    endtask

    initial begin
        IORST    = 1'b1;
        mybus    = 1'b1;
        req      = 1'b0;
        read     = 1'b0;
        addrl    = 2'd0;
        siz      = 2'd0;
        beats    = 3'd0;
        fcs_in_n = 1'b1;
        dtack_n  = 1'b1;
        slave_n  = 1'b1;
        tick();
        tick();
        check("rst.st", st, IDLE_V);
        check("rst.aboel", aboel, 1'b0);
        check("rst.mtcr", mtcr, 1'b0);
        IORST = 1'b0;
        tick();
        check("aboel", aboel, 1'b1);

        mybus = 1'b0;
        req   = 1'b1;
        repeat (3) tick();
        check("nobus", {aboel, aboeh}, 2'b00);
        req   = 1'b0;
        mybus = 1'b1;
        tick();

        tenure("lw0", 1'b0, 2'd0, 2'b00, 4'b0000, 4);
        tenure("bw3", 1'b0, 2'd3, 2'b01, 4'b1110, 1);
        tenure("bw0", 1'b0, 2'd0, 2'b01, 4'b0111, 1);
        tenure("ww1", 1'b0, 2'd1, 2'b10, 4'b1001, 2);
        tenure("ww3", 1'b0, 2'd3, 2'b10, 4'b1110, 1);
        tenure("lw2", 1'b0, 2'd2, 2'b00, 4'b1100, 1);
        tenure("tw1", 1'b0, 2'd1, 2'b11, 4'b1000, 1);
        tenure("rd2", 1'b1, 2'd2, 2'b01, 4'b0000, 2);

        blocked("fcs", 0);
        blocked("dtk", 1);
        blocked("slv", 2);

        slow("tmo", -1);
        slow("tie", TO - 1);

        to_data();
        check("rst.data", ds_n, 4'b0000);
        IORST = 1'b1;
        tick();
        check("rst.mid", {ds_n, efcs, aboeh, aboel}, 7'b1111_000);
        IORST = 1'b0;
        req   = 1'b0;
        tick();
        check("rst.after", {st, aboel}, {IDLE_V, 1'b1});

        read  = 1'b0;
        addrl = 2'd0;
        siz   = 2'd0;
        req   = 1'b1;
        repeat (4) tick();
        check("abt.doe", {doe, ds_n}, 5'b1_1111);
        req = 1'b0;
        tick();
        check("abt.term", {done, err, ds_n, efcs, doe}, 8'b00_1111_00);
        tick();
        check("abt.idle", st, IDLE_V);

        burst("b3", 3'd3, BURST ? 3 : 1);
        burst("b0", 3'd0, 1);
        burst("b7", 3'd7, BURST ? BM : 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
